// File: rtl/axi_framebuffer_reader_if.sv
// rtl/axi_framebuffer_reader_if.sv - AXI4 read channels plus AXI4-Stream output of the framebuffer reader
interface axi_framebuffer_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int ID_WIDTH   = 10
);
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_framebuffer_reader.sv
// rtl/axi_framebuffer_reader.sv - AXI4 burst reader streaming a frame region out as AXI4-Stream words
// Optional continuous frame looping is enabled by defining FB_READER_LOOP_EN.
module axi_framebuffer_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int ID_WIDTH   = 10,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   frame_words,
  output logic                   busy,
  output logic                   rerr,
  axi_framebuffer_reader_if.master bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0]        PTR_ONE = CW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic [LEN_WIDTH-1:0]   frame_q;
  logic [LEN_WIDTH-1:0]   out_cnt_q;
  logic [CW-1:0]          beats_q;
  logic                   arvalid_q;
  logic [ADDR_WIDTH-1:0]  araddr_q;
  logic [7:0]             arlen_q;
  logic                   busy_q;
  logic                   rerr_q;
`ifdef FB_READER_LOOP_EN
  logic [ADDR_WIDTH-1:0]  base_q;
`endif

  logic                   in_valid_q;
  logic [DATA_WIDTH-1:0]  in_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [CW-1:0]          wr_ptr_q;
  logic [CW-1:0]          rd_ptr_q;
  logic [CW-1:0]          used_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q;

  logic [CW-1:0]          beats_d;
  logic [CW-1:0]          free_slots;
  logic [ADDR_WIDTH-1:0]  addr_step;
  logic                   r_fire;
  logic                   pop;
  logic                   load;

  // used_q counts every beat from R acceptance until it leaves the stream
  // port, so the burst gate below also covers the input stage in flight.
  assign free_slots = CW'(FIFO_DEPTH) - used_q;
  assign beats_d    = (remaining_q < LEN_WIDTH'(BURST_LEN)) ? CW'(remaining_q) : CW'(BURST_LEN);
  assign addr_step  = ADDR_WIDTH'(beats_q) << $clog2(BYTES);
  assign r_fire     = bus.m_axi_rvalid && (state_q == S_DATA);
  assign pop        = tvalid_q && bus.m_axis_tready;
  assign load       = (wr_ptr_q != rd_ptr_q) && (!tvalid_q || pop);

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'($clog2(BYTES));
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'd0;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = 1'b1;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tvalid_q && (out_cnt_q == frame_q - LEN_ONE);
  assign busy = busy_q;
  assign rerr = rerr_q;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      frame_q     <= '0;
      out_cnt_q   <= '0;
      beats_q     <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      busy_q      <= 1'b0;
      rerr_q      <= 1'b0;
`ifdef FB_READER_LOOP_EN
      base_q      <= '0;
`endif
    end else begin
      if (pop) begin
`ifdef FB_READER_LOOP_EN
        out_cnt_q <= (out_cnt_q == frame_q - LEN_ONE) ? '0 : out_cnt_q + LEN_ONE;
`else
        out_cnt_q <= out_cnt_q + LEN_ONE;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (start && frame_words != '0) begin
            addr_q      <= base_addr;
            remaining_q <= frame_words;
            frame_q     <= frame_words;
            out_cnt_q   <= '0;
            rerr_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ADDR;
`ifdef FB_READER_LOOP_EN
            base_q      <= base_addr;
`endif
          end
        end
        S_ADDR: begin
          if (!arvalid_q) begin
            if (free_slots >= beats_d) begin
              arvalid_q <= 1'b1;
              araddr_q  <= addr_q;
              arlen_q   <= 8'(beats_d - PTR_ONE);
              beats_q   <= beats_d;
            end
          end else if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_fire) begin
            if (bus.m_axi_rresp != 2'b00) rerr_q <= 1'b1;
            if (bus.m_axi_rlast) begin
              if (remaining_q == LEN_WIDTH'(beats_q)) begin
`ifdef FB_READER_LOOP_EN
                addr_q      <= base_q;
                remaining_q <= frame_q;
                state_q     <= S_ADDR;
`else
                remaining_q <= '0;
                state_q     <= S_DRAIN;
`endif
              end else begin
                addr_q      <= addr_q + addr_step;
                remaining_q <= remaining_q - LEN_WIDTH'(beats_q);
                state_q     <= S_ADDR;
              end
            end
          end
        end
        S_DRAIN: begin
          if (out_cnt_q == frame_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Beat path: R capture register -> memory -> registered stream head.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      in_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      in_valid_q <= r_fire;
      if (in_valid_q) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        tvalid_q <= 1'b1;
      end else if (pop) begin
        tvalid_q <= 1'b0;
      end
      used_q <= used_q + CW'(r_fire) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    in_data_q <= bus.m_axi_rdata;
    if (in_valid_q) mem_q[wr_ptr_q[PW-1:0]] <= in_data_q;
    if (load) tdata_q <= mem_q[rd_ptr_q[PW-1:0]];
  end
endmodule

// File: tb/tb_axi_framebuffer_reader.sv
// tb/tb_axi_framebuffer_reader.sv - randomized self-checking bench for axi_framebuffer_reader
`timescale 1ns/1ps
module tb_axi_framebuffer_reader;
  localparam int DW = 32, AW = 19, IW = 10, BL = 16, FD = 64, LW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic [3:0]    cache;
    logic [2:0]    prot;
    logic [IW-1:0] id;
  } ar_t;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] frame_words = '0;
  logic          busy, rerr;

  int total = 0, bad = 0, cyc = 0;
  ar_t           ar_log[$];
  ar_t           pend[$];
  int            beat_idx = 0;
  logic [DW-1:0] out_data[$];
  logic          out_last[$];
  int            tready_mode = 0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  int            first_r_cyc = -1, first_tv_cyc = -1;

  axi_framebuffer_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_framebuffer_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .BURST_LEN(BL), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .frame_words(frame_words), .busy(busy), .rerr(rerr), .bus(bus)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // SRAM content: a fixed hash of the byte address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] b, input int i);
    return mem_word(b + AW'(i * 4));
  endfunction

  // AXI read slave: decisions made at negedge apply to the following posedge.
  initial begin : slave
    ar_t cur;
    bit new_ar;
    logic [AW-1:0] a;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rid     = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        pend.delete();
        beat_idx = 0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_arready = 1'b0;
      end else begin
        bus.m_axi_arready = ($urandom_range(0, 3) != 0);
        new_ar = 1'b0;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          cur.addr = bus.m_axi_araddr;   cur.len = bus.m_axi_arlen;
          cur.size = bus.m_axi_arsize;   cur.burst = bus.m_axi_arburst;
          cur.lock = bus.m_axi_arlock;   cur.cache = bus.m_axi_arcache;
          cur.prot = bus.m_axi_arprot;   cur.id = bus.m_axi_arid;
          ar_log.push_back(cur);
          pend.push_back(cur);
          new_ar = 1'b1;
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        if (!new_ar && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          a = pend[0].addr + AW'(beat_idx * 4);
          bus.m_axi_rdata  = mem_word(a);
          bus.m_axi_rresp  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
          bus.m_axi_rlast  = (beat_idx == int'(pend[0].len));
          bus.m_axi_rvalid = 1'b1;
          if (first_r_cyc < 0) first_r_cyc = cyc + 1;
          if (bus.m_axi_rlast) begin
            void'(pend.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  initial begin : sink
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      bus.m_axis_tready = (tready_mode == 0) ? 1'b1 :
                          (tready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (resetn && bus.m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (resetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
        out_data.push_back(bus.m_axis_tdata);
        out_last.push_back(bus.m_axis_tlast);
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] b, input int n);
    @(negedge aclk);
    ar_log.delete(); out_data.delete(); out_last.delete();
    first_r_cyc = -1; first_tv_cyc = -1;
    base_addr = b; frame_words = LW'(n); start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge aclk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rerr !== 1'b0) begin bad++; $display("FAIL reset_rerr got=%b exp=0", rerr); end
    total++; if (bus.m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", bus.m_axi_arvalid); end
    total++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin
      bad++; $display("FAIL reset_tvalid_tlast got=%b%b exp=00", bus.m_axis_tvalid, bus.m_axis_tlast); end
    total++; if (bus.m_axi_rready !== 1'b1) begin bad++; $display("FAIL reset_rready got=%b exp=1", bus.m_axi_rready); end
    resetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_zero_len();
    start_frame(19'h300, 0);
    @(negedge aclk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_len_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    tready_mode = 0;
    start_frame(19'h100, 40);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done busy still high exp=idle"); end
    total++; if (ar_log.size() != 3) begin bad++; $display("FAIL basic_bursts got=%0d exp=3", ar_log.size()); end
    for (int k = 0; k < ar_log.size() && k < 3; k++) begin
      total++;
      if (ar_log[k].addr !== AW'(19'h100 + k * 64) || ar_log[k].len !== ((k == 2) ? 8'd7 : 8'd15)) begin
        bad++; $display("FAIL basic_ar k=%0d got=%h/%0d exp=%h/%0d", k, ar_log[k].addr, ar_log[k].len,
                        19'h100 + k * 64, (k == 2) ? 7 : 15);
      end
      total++;
      if ({ar_log[k].size, ar_log[k].burst, ar_log[k].lock, ar_log[k].cache, ar_log[k].prot, ar_log[k].id}
          !== {3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 10'd0}) begin
        bad++; $display("FAIL basic_ar_const k=%0d size=%0d burst=%0d exp size=2 burst=1 rest=0",
                        k, ar_log[k].size, ar_log[k].burst);
      end
    end
    total++; if (out_data.size() != 40) begin bad++; $display("FAIL basic_words got=%0d exp=40", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 40; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h100, i) || out_last[i] !== (i == 39)) begin
        bad++; $display("FAIL basic_word i=%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i],
                        exp_word(19'h100, i), i == 39);
      end
    end
    total++;
    if (first_tv_cyc - first_r_cyc < 2) begin
      bad++; $display("FAIL basic_latency got=%0d exp>=2", first_tv_cyc - first_r_cyc);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [AW-1:0] b;
    int n, nb, exp_len;
    tready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      b = (t == 0) ? 19'h7FFF0 : AW'($urandom) & 19'h7FFFC;
      n = (t == 0) ? 10 : $urandom_range(1, 70);
      start_frame(b, n);
      wait_idle(ok);
      nb = (n + BL - 1) / BL;
      total++;
      if (!ok || ar_log.size() != nb || out_data.size() != n) begin
        bad++; $display("FAIL rand_counts t=%0d bursts=%0d/%0d words=%0d/%0d idle=%b", t,
                        ar_log.size(), nb, out_data.size(), n, ok);
      end
      for (int k = 0; k < ar_log.size() && k < nb; k++) begin
        exp_len = ((n - k * BL) < BL ? (n - k * BL) : BL) - 1;
        total++;
        if (ar_log[k].addr !== b + AW'(k * BL * 4) || int'(ar_log[k].len) != exp_len) begin
          bad++; $display("FAIL rand_ar t=%0d k=%0d got=%h/%0d exp=%h/%0d", t, k, ar_log[k].addr,
                          ar_log[k].len, b + AW'(k * BL * 4), exp_len);
        end
      end
      for (int i = 0; i < out_data.size() && i < n; i++) begin
        total++;
        if (out_data[i] !== exp_word(b, i) || out_last[i] !== (i == n - 1)) begin
          bad++; $display("FAIL rand_word t=%0d i=%0d got=%h/%b exp=%h/%b", t, i, out_data[i],
                          out_last[i], exp_word(b, i), i == n - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    tready_mode = 2;
    start_frame(19'h2000, 100);
    repeat (400) @(negedge aclk);
    total++; if (ar_log.size() != 4) begin bad++; $display("FAIL bp_bursts got=%0d exp=4", ar_log.size()); end
    total++; if (bus.m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL bp_arvalid got=%b exp=0", bus.m_axi_arvalid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b exp=1", busy); end
    tready_mode = 1;
    wait_idle(ok);
    total++; if (!ok || out_data.size() != 100) begin
      bad++; $display("FAIL bp_words got=%0d exp=100 idle=%b", out_data.size(), ok); end
    for (int i = 0; i < out_data.size() && i < 100; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h2000, i) || out_last[i] !== (i == 99)) begin
        bad++; $display("FAIL bp_word i=%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i],
                        exp_word(19'h2000, i), i == 99);
      end
    end
  endtask

  task automatic test_rerr();
    bit ok;
    tready_mode = 1;
    err_en = 1'b1; err_addr = 19'h400 + 19'd20;
    start_frame(19'h400, 20);
    wait_idle(ok);
    err_en = 1'b0;
    total++; if (rerr !== 1'b1) begin bad++; $display("FAIL rerr_set got=%b exp=1", rerr); end
    total++; if (out_data.size() != 20) begin bad++; $display("FAIL rerr_words got=%0d exp=20", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 20; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h400, i)) begin
        bad++; $display("FAIL rerr_word i=%0d got=%h exp=%h", i, out_data[i], exp_word(19'h400, i));
      end
    end
    repeat (5) @(negedge aclk);
    total++; if (rerr !== 1'b1) begin bad++; $display("FAIL rerr_sticky got=%b exp=1", rerr); end
    start_frame(19'h800, 8);
    total++; if (rerr !== 1'b0) begin bad++; $display("FAIL rerr_clear got=%b exp=0", rerr); end
    wait_idle(ok);
    total++; if (!ok || rerr !== 1'b0) begin bad++; $display("FAIL rerr_clean got=%b exp=0 idle=%b", rerr, ok); end
  endtask

  task automatic test_start_busy();
    bit ok;
    tready_mode = 1;
    start_frame(19'h1000, 30);
    repeat (5) @(negedge aclk);
    base_addr = 19'h3000; frame_words = 7; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_idle(ok);
    total++; if (!ok || out_data.size() != 30 || ar_log.size() != 2) begin
      bad++; $display("FAIL busy_start words=%0d exp=30 bursts=%0d exp=2", out_data.size(), ar_log.size()); end
    for (int k = 0; k < ar_log.size() && k < 2; k++) begin
      total++;
      if (ar_log[k].addr !== AW'(19'h1000 + k * 64)) begin
        bad++; $display("FAIL busy_ar k=%0d got=%h exp=%h", k, ar_log[k].addr, 19'h1000 + k * 64);
      end
    end
    for (int i = 0; i < out_data.size() && i < 30; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h1000, i) || out_last[i] !== (i == 29)) begin
        bad++; $display("FAIL busy_word i=%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i],
                        exp_word(19'h1000, i), i == 29);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    tready_mode = 0;
    start_frame(19'h5000, 60);
    for (int i = 0; i < 200 && first_r_cyc < 0; i++) @(negedge aclk);
    total++; if (first_r_cyc < 0) begin bad++; $display("FAIL rstmid_no_beat got=none exp=beat"); end
    repeat (3) @(negedge aclk);
    resetn = 1'b0;
    @(posedge aclk); #1;
    total++;
    if ({busy, rerr, bus.m_axi_arvalid, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axi_rready} !== 6'b000001) begin
      bad++; $display("FAIL rstmid_outputs got=%b exp=000001",
                      {busy, rerr, bus.m_axi_arvalid, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axi_rready});
    end
    @(negedge aclk); @(negedge aclk);
    resetn = 1'b1;
    start_frame(19'h6004, 25);
    wait_idle(ok);
    total++; if (!ok || out_data.size() != 25 || ar_log.size() != 2) begin
      bad++; $display("FAIL rstmid_counts words=%0d exp=25 bursts=%0d exp=2", out_data.size(), ar_log.size()); end
    if (ar_log.size() == 2) begin
      total++;
      if (ar_log[0].addr !== 19'h6004 || ar_log[0].len !== 8'd15 || ar_log[1].addr !== 19'h6044 || ar_log[1].len !== 8'd8) begin
        bad++; $display("FAIL rstmid_ar got=%h/%0d %h/%0d exp=06004/15 06044/8", ar_log[0].addr,
                        ar_log[0].len, ar_log[1].addr, ar_log[1].len);
      end
    end
    for (int i = 0; i < out_data.size() && i < 25; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h6004, i) || out_last[i] !== (i == 24)) begin
        bad++; $display("FAIL rstmid_word i=%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i],
                        exp_word(19'h6004, i), i == 24);
      end
    end
  endtask

  task automatic test_loop();
    tready_mode = 1;
    start_frame(19'h200, 20);
    for (int i = 0; i < 3000 && out_data.size() < 60; i++) @(negedge aclk);
    total++; if (out_data.size() < 60 || ar_log.size() < 6) begin
      bad++; $display("FAIL loop_counts words=%0d exp>=60 bursts=%0d exp>=6", out_data.size(), ar_log.size()); end
    for (int k = 0; k < ar_log.size() && k < 6; k++) begin
      total++;
      if (ar_log[k].addr !== ((k % 2 == 0) ? 19'h200 : 19'h240) || ar_log[k].len !== ((k % 2 == 0) ? 8'd15 : 8'd3)) begin
        bad++; $display("FAIL loop_ar k=%0d got=%h/%0d", k, ar_log[k].addr, ar_log[k].len);
      end
    end
    for (int i = 0; i < out_data.size() && i < 60; i++) begin
      total++;
      if (out_data[i] !== exp_word(19'h200, i % 20) || out_last[i] !== (i % 20 == 19)) begin
        bad++; $display("FAIL loop_word i=%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i],
                        exp_word(19'h200, i % 20), i % 20 == 19);
      end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL loop_busy got=%b exp=1", busy); end
  endtask

  initial begin
    test_reset();
`ifdef FB_READER_LOOP_EN
    test_loop();
`else
    test_zero_len();
    test_basic();
    test_random();
    test_backpressure();
    test_rerr();
    test_start_busy();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
